// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, prefix codes and FIFO entry width for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam int PS2_ENTRY_W = 10;
endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: first-word fall-through FIFO with push/pop, full/empty and occupancy count
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // a push into a full FIFO lands only when the head leaves in the same cycle
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = empty ? '0 : mem_q[rd_q];
    count = cnt_q;
  end
  // storage needs no reset; the head is masked while empty
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  // pointers and occupancy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ps2_rx_decoder.sv
// ps2_rx_decoder: system-clocked PS/2 receiver with filter, deframer, prefix folding and key FIFO; PS2_PARITY_CHECK_EN enables parity rejection
module ps2_rx_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic [7:0]                  out_code,
  output logic                        out_break,
  output logic                        out_ext,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  import ps2_pkg::*;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam logic PAR_CHK = 1'b1;
`else
  localparam logic PAR_CHK = 1'b0;
`endif
  logic [SYNC_STAGES-1:0] csync_q, csync_d, dsync_q, dsync_d;
  logic filt_q, filt_d, prev_q, prev_d, ext_q, ext_d, brk_q, brk_d, ovf_q, ovf_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic sclk, sdat, hit, fe;
  ps2_state_e state_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic par_ok_q, done_q, err_q;
  logic [TW-1:0] tmo_q;
  logic push, pop, full, empty, is_ext, is_brk;
  logic [PS2_ENTRY_W-1:0] head;
  // synchroniser shift, clock glitch filter and falling-edge strobe
  always_comb begin
    csync_d = {csync_q[SYNC_STAGES-2:0], ps2_clk};
    dsync_d = {dsync_q[SYNC_STAGES-2:0], ps2_data};
    sclk = csync_q[SYNC_STAGES-1];
    sdat = dsync_q[SYNC_STAGES-1];
    hit = (sclk != filt_q) && (fcnt_q == 3'(FILT_LEN - 1));
    filt_d = hit ? sclk : filt_q;
    fcnt_d = (sclk != filt_q && !hit) ? fcnt_q + 3'd1 : 3'd0;
    prev_d = filt_q;
    fe = prev_q & ~filt_q;
  end
  // prefix flags fold into the next real key; both clear once that key is offered
  always_comb begin
    is_ext = shift_q == PS2_PFX_EXT;
    is_brk = shift_q == PS2_PFX_BRK;
    push = done_q & ~is_ext & ~is_brk;
    pop = ~empty & out_ready;
    ext_d = done_q ? is_ext | (is_brk & ext_q) : ext_q;
    brk_d = done_q ? is_brk | (is_ext & brk_q) : brk_q;
    ovf_d = push & full & ~pop;
  end
  // front-end, prefix and overflow registers; idle line level is high
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      csync_q <= '1;
      dsync_q <= '1;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      fcnt_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      csync_q <= csync_d;
      dsync_q <= dsync_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      fcnt_q <= fcnt_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      ovf_q <= ovf_d;
    end
  // frame FSM stepping on falling edges, with inter-edge timeout
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      shift_q <= '0;
      par_ok_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= (fe || state_q == IDLE) ? '0 : tmo_q + TW'(1);
      if (state_q != IDLE && !fe && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_q <= IDLE;
        err_q <= 1'b1;
      end else if (fe) begin
        case (state_q)
          IDLE: if (sdat) err_q <= 1'b1; else begin state_q <= DATA; idx_q <= '0; end
          DATA: begin
            shift_q <= {sdat, shift_q[7:1]};
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_ok_q <= ^{sdat, shift_q} | ~PAR_CHK;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (sdat && par_ok_q) done_q <= 1'b1; else err_q <= 1'b1;
          end
        endcase
      end
    end
  ps2_sync_fifo #(.WIDTH(PS2_ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({ext_q, brk_q, shift_q}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign {out_ext, out_break, out_code} = head;
  assign out_valid = ~empty;
  assign frame_err = err_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_ps2_rx_decoder.sv
// tb_ps2_rx_decoder: PS/2 frame vectors and corner sequences checked through an entry scoreboard
module tb_ps2_rx_decoder;
  localparam int SS = 2, FL = 4, TO = 500, FD = 4, H = 20;
  logic clk = 0, rst = 0, ps2_clk = 1, ps2_data = 1, out_ready = 1;
  logic [7:0] out_code;
  logic out_break, out_ext, out_valid, frame_err, overflow;
  logic [$clog2(FD):0] fifo_count;
  int checks = 0, errors = 0, err_cnt = 0, ovf_cnt = 0;
  logic [9:0] sb [$];
  typedef struct { logic [7:0] code; bit bad; bit push; logic [9:0] exp; int err; } vec_t;
  vec_t tbl [12];
  logic [7:0] burst [5];

  always #5 clk = ~clk;

  ps2_rx_decoder #(.SYNC_STAGES(SS), .FILT_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_code(out_code), .out_break(out_break), .out_ext(out_ext), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // entries leave the DUT here and are matched against the scoreboard
  always @(negedge clk) begin
    #1;
    if (frame_err) err_cnt++;
    if (overflow) ovf_cnt++;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got %0h expected none", {out_ext, out_break, out_code});
      end else chk("entry", {22'd0, out_ext, out_break, out_code}, {22'd0, sb.pop_front()});
    end
  end

  // sends the first nbits of an 11-bit frame; lat = cycles from stop-bit fall to out_valid
  task automatic send(input logic [7:0] code, input bit bad, input int nbits, output int lat);
    logic [10:0] bits;
    bits = {1'b1, ~^code ^ bad, code, 1'b0};
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 0;
      for (int n = 1; n <= H; n++) begin
        @(posedge clk);
        @(negedge clk);
        if (i == 10 && lat < 0 && out_valid) lat = n;
      end
      ps2_clk = 1;
    end
    ps2_data = 1;
    repeat (H) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_code"}, out_code, 0);
    chk({tag, "_brk"}, out_break, 0);
    chk({tag, "_ext"}, out_ext, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_count"}, fifo_count, 0);
  endtask

  initial begin
    int lat, e0, o0;
    tbl[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 0};
    tbl[1]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 0};
    tbl[2]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 0};
    tbl[3]  = '{8'h75, 1'b0, 1'b1, 10'h375, 0};
    tbl[4]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 0};
    tbl[5]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 0};
    tbl[6]  = '{8'h6B, 1'b0, 1'b1, 10'h26B, 0};
    tbl[7]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 0};
`ifdef PS2_PARITY_CHECK_EN
    tbl[8]  = '{8'h1C, 1'b1, 1'b0, 10'h000, 1};
    tbl[9]  = '{8'h1C, 1'b0, 1'b1, 10'h11C, 0};
`else
    tbl[8]  = '{8'h1C, 1'b1, 1'b1, 10'h11C, 0};
    tbl[9]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 0};
`endif
    tbl[10] = '{8'hFF, 1'b0, 1'b1, 10'h0FF, 0};
    tbl[11] = '{8'h00, 1'b0, 1'b1, 10'h000, 0};
    burst = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1;
    repeat (5) @(negedge clk);

    sb.push_back(10'h01C);
    send(8'h1C, 1'b0, 11, lat);
    chk("t1_latency", lat, SS + FL + 2);
    chk("t1_drain", sb.size(), 0);

    for (int k = 0; k < 12; k++) begin
      e0 = err_cnt;
      if (tbl[k].push) sb.push_back(tbl[k].exp);
      send(tbl[k].code, tbl[k].bad, 11, lat);
      chk($sformatf("v%0d_ferr", k), err_cnt - e0, tbl[k].err);
      chk($sformatf("v%0d_drain", k), sb.size(), 0);
    end

    e0 = err_cnt;
    send(8'h00, 1'b0, 6, lat);
    repeat (TO + 50) @(negedge clk);
    chk("t4_timeout_ferr", err_cnt - e0, 1);
    chk("t4_count", fifo_count, 0);
    e0 = err_cnt;
    sb.push_back(10'h032);
    send(8'h32, 1'b0, 11, lat);
    chk("t4_next_ferr", err_cnt - e0, 0);
    chk("t4_next_drain", sb.size(), 0);

    out_ready = 0;
    o0 = ovf_cnt;
    for (int k = 0; k < 5; k++) begin
      if (k < FD) sb.push_back({2'b00, burst[k]});
      send(burst[k], 1'b0, 11, lat);
    end
    chk("t5_count", fifo_count, FD);
    chk("t5_ovf", ovf_cnt - o0, 1);
    chk("t5_head", out_code, 8'h15);
    chk("t5_valid", out_valid, 1);
    out_ready = 1;
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    chk("t5_drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    chk("t5_empty", fifo_count, 0);

    out_ready = 0;
    send(8'h1C, 1'b0, 11, lat);
    chk("t6_parked", fifo_count, 1);
    send(8'h29, 1'b0, 4, lat);
    rst = 0;
    @(negedge clk);
    chk_zero("t6_rst");
    repeat (3) @(negedge clk);
    chk("t6_rst_hold", fifo_count, 0);
    rst = 1;
    out_ready = 1;
    repeat (5) @(negedge clk);
    sb.push_back(10'h029);
    send(8'h29, 1'b0, 11, lat);
    chk("t6_drain", sb.size(), 0);
    chk("t6_count", fifo_count, 0);
    chk("ovf_total", ovf_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
